// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control FSM: opcodes, ALU codes,
// mux selects, state codes, and the state -> control-word mapping.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_LI   = 6'b011000;
    localparam logic [5:0] OP_LUI  = 6'b011001;
    localparam logic [5:0] OP_LWI  = 6'b011010;
    localparam logic [5:0] OP_SWI  = 6'b011011;
    localparam logic [5:0] OP_LW   = 6'b011100;
    localparam logic [5:0] OP_SW   = 6'b011101;
    localparam logic [5:0] OP_JMP  = 6'b110000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_ZE16   = 2'b01;
    localparam logic [1:0] M2R_DMEM   = 2'b10;
    localparam logic [1:0] M2R_LUI    = 2'b11;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_SE16 = 2'b10;
    localparam logic [1:0] SRCB_ZE16 = 2'b11;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        LI_WB    = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd12,
        TRAP     = 4'd13
    } state_t;

    typedef struct packed {
        logic       is_r;
        logic       is_imm_se;
        logic       is_imm_ze;
        logic       is_li;
        logic       is_lui;
        logic       is_load;
        logic       is_store;
        logic       is_direct;
        logic       is_branch;
        logic       is_jmp;
        logic       is_halt;
        logic       illegal;
        logic [2:0] alu_sel;
        logic [1:0] bcond;
    } opc_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       ir_write;
        logic       mem_write;
        logic       mem_addr;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       reg_read;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_select;
        logic [1:0] branch_cond;
        logic       halted;
        logic       illegal_op;
    } ctrl_t;

    // DECODE's RegRead depends on the live opcode and is added in the top.
    function automatic ctrl_t ctrl_for(input state_t s, input opc_class_t c);
        ctrl_t o;
        o = '0;
        case (s)
            FETCH: begin
                o.ir_write   = 1'b1;
                o.alu_src_b  = SRCB_ONE;
                o.alu_select = ALU_ADD;
                o.pc_source  = PCS_ALU;
                o.pc_write   = 1'b1;
            end
            DECODE: begin
                o.alu_src_b  = SRCB_SE16;
                o.alu_select = ALU_ADD;
            end
            EXEC_R: begin
                o.alu_src_a  = 1'b1;
                o.alu_src_b  = SRCB_B;
                o.alu_select = c.alu_sel;
            end
            EXEC_I: begin
                o.alu_src_a  = 1'b1;
                o.alu_src_b  = c.is_imm_ze ? SRCB_ZE16 : SRCB_SE16;
                o.alu_select = c.alu_sel;
            end
            ALU_WB: begin
                o.mem_to_reg = M2R_ALUOUT;
                o.reg_write  = 1'b1;
            end
            LI_WB: begin
                o.mem_to_reg = c.is_lui ? M2R_LUI : M2R_ZE16;
                o.reg_write  = 1'b1;
            end
            MEM_ADDR: begin
                o.alu_src_a  = 1'b1;
                o.alu_src_b  = SRCB_SE16;
                o.alu_select = ALU_ADD;
                o.reg_read   = 1'b1;
            end
            MEM_RD: o.mem_addr = c.is_direct;
            MEM_WB: begin
                o.mem_to_reg = M2R_DMEM;
                o.reg_write  = 1'b1;
                o.mem_addr   = c.is_direct;
            end
            MEM_WR: begin
                o.mem_write = 1'b1;
                o.reg_read  = 1'b1;
                o.mem_addr  = c.is_direct;
            end
            BRANCH: begin
                o.alu_src_a     = 1'b1;
                o.alu_src_b     = SRCB_B;
                o.alu_select    = ALU_SUB;
                o.reg_read      = 1'b1;
                o.pc_write_cond = 1'b1;
                o.pc_source     = PCS_ALUOUT;
                o.branch_cond   = c.bcond;
            end
            JUMP: begin
                o.pc_source = PCS_JUMP;
                o.pc_write  = 1'b1;
            end
            HALT: o.halted = 1'b1;
            TRAP: begin
                o.halted     = 1'b1;
                o.illegal_op = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier for the multicycle control FSM.
module mc_opcode_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_r,
    output logic       is_imm_se,
    output logic       is_imm_ze,
    output logic       is_li,
    output logic       is_lui,
    output logic       is_load,
    output logic       is_store,
    output logic       is_direct,
    output logic       is_branch,
    output logic       is_jmp,
    output logic       is_halt,
    output logic       illegal
);

    always_comb begin
        is_r      = 1'b0;
        is_imm_se = 1'b0;
        is_imm_ze = 1'b0;
        is_li     = 1'b0;
        is_lui    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_direct = 1'b0;
        is_branch = 1'b0;
        is_jmp    = 1'b0;
        is_halt   = 1'b0;
        illegal   = 1'b0;
        casez (opcode)
            6'b000???: is_r      = 1'b1;
            6'b001???: is_imm_se = 1'b1;
            6'b010???: is_imm_ze = 1'b1;
            OP_LI:     is_li     = 1'b1;
            OP_LUI:    is_lui    = 1'b1;
            OP_LWI: begin
                is_load   = 1'b1;
                is_direct = 1'b1;
            end
            OP_SWI: begin
                is_store  = 1'b1;
                is_direct = 1'b1;
            end
            OP_LW:     is_load   = 1'b1;
            OP_SW:     is_store  = 1'b1;
            6'b1000??: is_branch = 1'b1;
            OP_JMP:    is_jmp    = 1'b1;
            OP_HALT:   is_halt   = 1'b1;
            default:   illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle CPU datapath.
// Build option: MC_ILLEGAL_TRAP_EN sends illegal opcodes to an absorbing TRAP state.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W    = 6,
    parameter int ALUSEL_W = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [OPC_W-1:0]    Opcode,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic [1:0]          PCSource,
    output logic                IRWrite,
    output logic                MemWrite,
    output logic                MemAddr,
    output logic [1:0]          MemtoReg,
    output logic                RegWrite,
    output logic                RegRead,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUSEL_W-1:0] ALUSelect,
    output logic [1:0]          BranchCond,
    output logic                Halted,
    output logic                IllegalOp,
    output logic [3:0]          State
);

    opc_class_t live;
    opc_class_t cls_q, cls_n;
    state_t     state_q, nxt;
    ctrl_t      ctrl_q, ctrl_n;

    mc_opcode_decode u_decode (
        .opcode    (Opcode[5:0]),
        .is_r      (live.is_r),
        .is_imm_se (live.is_imm_se),
        .is_imm_ze (live.is_imm_ze),
        .is_li     (live.is_li),
        .is_lui    (live.is_lui),
        .is_load   (live.is_load),
        .is_store  (live.is_store),
        .is_direct (live.is_direct),
        .is_branch (live.is_branch),
        .is_jmp    (live.is_jmp),
        .is_halt   (live.is_halt),
        .illegal   (live.illegal)
    );

    assign live.alu_sel = Opcode[2:0];
    assign live.bcond   = Opcode[1:0];

    always_comb begin
        nxt   = state_q;
        cls_n = cls_q;
        case (state_q)
            FETCH: nxt = DECODE;
            DECODE: begin
                cls_n = live;
                if (live.is_r)                          nxt = EXEC_R;
                else if (live.is_imm_se || live.is_imm_ze) nxt = EXEC_I;
                else if (live.is_li || live.is_lui)     nxt = LI_WB;
                else if ((live.is_load || live.is_store) && !live.is_direct) nxt = MEM_ADDR;
                else if (live.is_load)                  nxt = MEM_RD;
                else if (live.is_store)                 nxt = MEM_WR;
                else if (live.is_branch)                nxt = BRANCH;
                else if (live.is_jmp)                   nxt = JUMP;
                else if (live.is_halt)                  nxt = HALT;
                else begin
`ifdef MC_ILLEGAL_TRAP_EN
                    nxt = TRAP;
`else
                    nxt = FETCH;
`endif
                end
            end
            EXEC_R, EXEC_I: nxt = ALU_WB;
            MEM_ADDR: nxt = cls_q.is_load ? MEM_RD : MEM_WR;
            MEM_RD:   nxt = MEM_WB;
            ALU_WB, LI_WB, MEM_WB, MEM_WR, BRANCH, JUMP: nxt = FETCH;
            HALT:     nxt = HALT;
            TRAP:     nxt = TRAP;
            default:  nxt = FETCH;
        endcase
`ifdef MC_ILLEGAL_TRAP_EN
        ctrl_n = ctrl_for(nxt, cls_n);
`else
        ctrl_n            = ctrl_for(nxt, cls_n);
        ctrl_n.illegal_op = 1'b0;
`endif
    end

    // Control word is registered alongside the state it belongs to.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= FETCH;
            cls_q   <= '0;
            ctrl_q  <= ctrl_for(FETCH, '0);
        end else begin
            state_q <= nxt;
            cls_q   <= cls_n;
            ctrl_q  <= ctrl_n;
        end
    end

    assign PCWrite     = ctrl_q.pc_write;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign PCSource    = ctrl_q.pc_source;
    assign IRWrite     = ctrl_q.ir_write;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemAddr     = ctrl_q.mem_addr;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegWrite    = ctrl_q.reg_write;
    // In DECODE the IR has only just loaded, so Read2 select follows the live opcode.
    assign RegRead     = ctrl_q.reg_read |
                         ((state_q == DECODE) && (live.is_store || live.is_branch));
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUSelect   = ctrl_q.alu_select;
    assign BranchCond  = ctrl_q.branch_cond;
    assign Halted      = ctrl_q.halted;
    assign IllegalOp   = ctrl_q.illegal_op;
    assign State       = state_q;

endmodule
